bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.
- Successor to the lab's fixed 4-bit combinational code converters: generic binary width and digit count, start/done handshake, registered output.
- Feeds BCD-digit displays and downstream digit-code converters in the lab designs.

Parameters:
- W, 8, width of the binary input (W >= 1).
- D, 3, number of BCD output digits; must satisfy 10^D > 2^W - 1 for overflow-free results.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_b  input  1  asynchronous active-low reset.
- start_i  input  1  request conversion of bin_i; sampled only when busy_o = 0.
- bin_i  input  W  unsigned binary operand; sampled on the accepting edge only.
- busy_o  output  1  high while a conversion is in progress (state SHIFT).
- done_o  output  1  one-cycle pulse; bcd_o is valid from this cycle on.
- bcd_o  output  4*D  result digits; digit k occupies bits [4k+3:4k], digit 0 is least significant.
- ovf_o  output  1  present only with BIN2BCD_OVF_EN (see Optional Feature).

Behaviour:
- Reset (rst_b = 0, asynchronous): state IDLE, busy_o = 0, done_o = 0, bcd_o = 0, internal shift and scratch registers = 0, ovf_o = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: start_i = 1 moves to SHIFT.
  - SHIFT: stays for W cycles, then moves to DONE.
  - DONE: start_i = 1 moves to SHIFT (back-to-back conversions); otherwise moves to IDLE.
- Accept edge (IDLE or DONE with start_i = 1):
  - bin register loads bin_i.
  - Scratch register (4*D bits) clears to 0.
  - Bit counter loads W.
  - bcd_o keeps its previous value.
- Each SHIFT edge:
  - Every scratch digit >= 5 gets +3 (4-bit add, no carry between digits).
  - The {scratch, bin} concatenation then shifts left by 1; the bin MSB enters scratch bit 0.
  - The counter decrements.
- Completion: on the SHIFT edge where the counter goes 1 -> 0, bcd_o is loaded with the post-shift scratch, done_o is registered high, and the state moves to DONE.
- Latency: with the accept at edge 0, done_o is high in the cycle after edge W. bcd_o is valid from that cycle.
- done_o is high for exactly one cycle per conversion.
- busy_o = 1 exactly during the W SHIFT cycles.
- start_i while busy_o = 1 is ignored: no restart, no queueing, and bin_i is not sampled.
- bcd_o holds the last result until the next completion; it is never partially updated.
- W = 1 gives a 1-cycle SHIFT phase; bin_i = 1 yields bcd_o = 1.
- Reset mid-conversion aborts immediately: all values return to reset values and no done_o pulse is produced.
- Digit adjust uses >= 5 (not > 4 on a wider value); a digit can never exceed 9 after an adjusted shift.

Optional Feature:
- Macro: BIN2BCD_OVF_EN.
- Defined:
  - ovf_o port exists and is registered.
  - ovf_o clears on the accept edge.
  - On any SHIFT edge where the adjusted scratch bit 4*D-1 is 1 (that bit is lost by the shift), ovf_o sets and stays set (sticky) until the next accept edge or reset.
  - ovf_o is valid with done_o; bcd_o then holds the truncated low D digits.
- Undefined: no ovf_o port and no detection logic; a too-small D silently truncates.

Decomposition:
- Package bin2bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - DIGIT_W = 4, ADJ_THRESH = 5, ADJ_ADD = 3;
  - a counter-width function returning clog2(W+1).
- Sub-module bcd_digit_adj: combinational, 4-bit in, 4-bit out (add 3 when >= 5).
  - Instantiated D times via generate inside bin2bcd_seq.
- The top module holds the FSM, counter, shift registers, output registers and the optional overflow flag.

Test Plan:
- W=8, D=3, bin_i=255, start pulse → busy_o high 8 cycles; done_o pulse in the cycle after edge 8; bcd_o = 12'h255.
- bin_i=0, then bin_i=99 back-to-back (start held high during DONE) → bcd_o = 12'h000 then 12'h099; second conversion starts with no IDLE cycle.
- Sweep all 256 inputs → each bcd_o matches the reference decimal digits; exactly one done_o pulse per start.
- Start at edge 0 with bin_i=37; at edge 3 assert start_i with bin_i=200 → second request ignored; result 12'h037.
- rst_b low at cycle 4 of a conversion of 150 → outputs zero asynchronously; no done_o; a following conversion of 150 yields 12'h150.
- BIN2BCD_OVF_EN, W=8, D=2:
  - bin_i=200 → ovf_o = 1 with done_o, bcd_o = 8'h00.
  - bin_i=99 → ovf_o = 0, bcd_o = 8'h99.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // Bits needed for a counter that must hold the value w down to 0.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so
// that the following left shift carries correctly into the next digit.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Pure 4-bit add, no carry out; inputs 5..9 map to 8..12.
  always_comb begin
    adjusted = digit;
    if (digit >= ADJ_THRESH) begin
      adjusted = digit + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Optional overflow flag: define BIN2BCD_OVF_EN to add the sticky ovf_o
// output, which reports when a digit carry falls off the top digit.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 start_i,
  input  logic [W-1:0]         bin_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DIGIT_W*D-1:0] bcd_o
`ifdef BIN2BCD_OVF_EN
  ,
  output logic                 ovf_o
`endif
);

  localparam int             SW       = DIGIT_W * D;
  localparam int             CW       = cnt_width(W);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(W);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  state_t          state_reg, state_next;
  logic [W-1:0]    bin_reg, bin_next;
  logic [SW-1:0]   scr_reg, scr_next;
  logic [SW-1:0]   scr_adj;
  logic [SW-1:0]   bcd_reg, bcd_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done_reg, done_next;
  logic            accept;
  logic [SW+W-1:0] shifted;

  // One correction unit per digit of the scratch register.
  generate
    for (genvar gi = 0; gi < D; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit    (scr_reg[gi*DIGIT_W +: DIGIT_W]),
        .adjusted (scr_adj[gi*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // A new request is taken whenever no conversion is running.
  assign accept  = (state_reg != SHIFT) && start_i;

  // Shifting the whole {scratch, bin} word moves the bin MSB into scratch bit 0.
  assign shifted = {scr_adj, bin_reg} << 1;

  // Next-state and datapath update for the three-state control FSM.
  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    scr_next   = scr_reg;
    bcd_next   = bcd_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        state_next = IDLE;
        if (accept) begin
          state_next = SHIFT;
          bin_next   = bin_i;
          scr_next   = '0;
          cnt_next   = CNT_LOAD;
        end
      end
      SHIFT: begin
        scr_next = shifted[SW+W-1:W];
        bin_next = shifted[W-1:0];
        cnt_next = cnt_reg - CNT_ONE;
        // Last bit: publish the complete result in one go.
        if (cnt_reg == CNT_ONE) begin
          state_next = DONE;
          bcd_next   = shifted[SW+W-1:W];
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      scr_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      scr_reg   <= scr_next;
      bcd_reg   <= bcd_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  assign busy_o = (state_reg == SHIFT);
  assign done_o = done_reg;
  assign bcd_o  = bcd_reg;

`ifdef BIN2BCD_OVF_EN
  logic ovf_reg, ovf_next;

  // Sticky flag: the adjusted top bit is about to be shifted out.
  always_comb begin
    ovf_next = ovf_reg;
    if (accept) begin
      ovf_next = 1'b0;
    end else if (state_reg == SHIFT && scr_adj[SW-1]) begin
      ovf_next = 1'b1;
    end
  end

  // Overflow flag register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ovf_reg <= 1'b0;
    end else begin
      ovf_reg <= ovf_next;
    end
  end

  assign ovf_o = ovf_reg;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard testbench for bin2bcd_seq (W=8, D=3), plus a W=1 instance and,
// with BIN2BCD_OVF_EN, a W=8/D=2 instance for the overflow flag.
module tb_bin2bcd_seq;

  localparam int W = 8;
  localparam int D = 3;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic              start_i = 1'b0;
  logic [W-1:0]      bin_i = '0;
  logic              busy_o, done_o;
  logic [4*D-1:0]    bcd_o;

  logic              s1 = 1'b0;
  logic [0:0]        b1 = 1'b0;
  logic              busy1, done1;
  logic [3:0]        bcd1;

`ifdef BIN2BCD_OVF_EN
  logic              ovf_o, ovf1;
  logic              s2 = 1'b0;
  logic [7:0]        b2 = '0;
  logic              busy2, done2, ovf2;
  logic [7:0]        bcd2;
`endif

  bin2bcd_seq #(.W(W), .D(D)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start_i (start_i),
    .bin_i   (bin_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .bcd_o   (bcd_o)
`ifdef BIN2BCD_OVF_EN
    ,
    .ovf_o   (ovf_o)
`endif
  );

  bin2bcd_seq #(.W(1), .D(1)) dut_w1 (
    .clk     (clk),
    .rst_b   (rst_b),
    .start_i (s1),
    .bin_i   (b1),
    .busy_o  (busy1),
    .done_o  (done1),
    .bcd_o   (bcd1)
`ifdef BIN2BCD_OVF_EN
    ,
    .ovf_o   (ovf1)
`endif
  );

`ifdef BIN2BCD_OVF_EN
  bin2bcd_seq #(.W(8), .D(2)) dut_ovf (
    .clk     (clk),
    .rst_b   (rst_b),
    .start_i (s2),
    .bin_i   (b2),
    .busy_o  (busy2),
    .done_o  (done2),
    .bcd_o   (bcd2),
    .ovf_o   (ovf2)
  );
`endif

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_err  = 0;
  int n_done = 0;
  int n_acc  = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  // Reference decimal digits computed arithmetically.
  function automatic logic [11:0] ref_bcd(input int b);
    logic [3:0] h, t, u;
    h = 4'(b / 100);
    t = 4'((b / 10) % 10);
    u = 4'(b % 10);
    return {h, t, u};
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_b && done_o) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got bcd %0h required no done", bcd_o);
      end else begin
        check("bcd_result", 32'(bcd_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Issue a single start pulse and record the expected result.
  task automatic issue(input logic [W-1:0] b, input logic [11:0] expv);
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = b;
    exp_q.push_back(expv);
    n_acc++;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Wait (bounded) until the main DUT leaves SHIFT.
  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_done: got busy after 40 cycles required idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #12;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_bcd",  32'(bcd_o),  32'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 255: busy for exactly 8 cycles, done in the cycle after edge 8
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 8'd255;
    exp_q.push_back(12'h255);
    n_acc++;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_in_shift", 32'(busy_o), 32'd1);
      check("no_early_done", 32'(done_o), 32'd0);
      @(negedge clk);
    end
    check("busy_after_shift", 32'(busy_o), 32'd0);
    check("done_latency",     32'(done_o), 32'd1);
`ifdef BIN2BCD_OVF_EN
    check("ovf_main_255", 32'(ovf_o), 32'd0);
`endif
    @(negedge clk);
    check("done_one_cycle", 32'(done_o), 32'd0);
    check("bcd_hold_255",   32'(bcd_o),  32'h255);

    // 0 then 99 back-to-back with start held through DONE
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 8'd0;
    exp_q.push_back(12'h000);
    exp_q.push_back(12'h099);
    n_acc += 2;
    @(negedge clk);
    bin_i = 8'd99;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done_o) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        n_cmp++;
        n_err++;
        $display("FAIL b2b_done: got no done required done");
      end
    end
    @(negedge clk);
    check("b2b_no_idle_gap", 32'(busy_o), 32'd1);
    start_i = 1'b0;
    wait_done();

    // Start during busy is ignored
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 8'd37;
    exp_q.push_back(12'h037);
    n_acc++;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 8'd200;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();

    // Reset mid-conversion of 150
    @(negedge clk);
    start_i = 1'b1;
    bin_i   = 8'd150;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_b = 1'b0;
    #1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_bcd",  32'(bcd_o),  32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (12) @(negedge clk);
    issue(8'd150, 12'h150);
    wait_done();

    // W=1 boundary
    @(negedge clk);
    s1 = 1'b1;
    b1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    check("w1_busy", 32'(busy1), 32'd1);
    @(negedge clk);
    check("w1_busy_end", 32'(busy1), 32'd0);
    check("w1_done",     32'(done1), 32'd1);
    check("w1_bcd",      32'(bcd1),  32'd1);
`ifdef BIN2BCD_OVF_EN
    check("w1_ovf", 32'(ovf1), 32'd0);
`endif

    // Full sweep
    for (int b = 0; b < 256; b++) begin
      issue(8'(b), ref_bcd(b));
      wait_done();
    end

`ifdef BIN2BCD_OVF_EN
    // D=2 overflow: 200 truncates, 99 fits
    begin
      logic [7:0] vals[2];
      logic [7:0] bcds[2];
      logic       ovfs[2];
      vals[0] = 8'd200; bcds[0] = 8'h00; ovfs[0] = 1'b1;
      vals[1] = 8'd99;  bcds[1] = 8'h99; ovfs[1] = 1'b0;
      for (int v = 0; v < 2; v++) begin
        bit seen;
        @(negedge clk);
        s2 = 1'b1;
        b2 = vals[v];
        @(negedge clk);
        s2 = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
          @(negedge clk);
          if (done2) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          n_cmp++;
          n_err++;
          $display("FAIL ovf_done: got no done required done");
        end
        check("ovf_flag", 32'(ovf2), 32'(ovfs[v]));
        check("ovf_bcd",  32'(bcd2), 32'(bcds[v]));
      end
    end
`endif

    repeat (3) @(negedge clk);
    check("done_count",  32'(n_done),       32'(n_acc));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
